memory_ram_ws: RTL and testbench
================================

Name: memory_ram_ws

Overview:
Parametrised single-port synchronous RAM that replaces the fixed 8-bit-address, 32-bit RAM on the SoC data bus.
- Adds configurable data width and depth, per-byte write enables, and programmable wait states.
- Uses a request/acknowledge handshake with a busy indication, plus an out-of-range error response.
- Sits between the riscv32 core's data port and the SoC, and is the basis for slower-memory timing experiments.

Parameters:
DATA_W, 32, data word width in bits; must be a multiple of 8.
ADDR_W, 8, word-address width.
DEPTH, 256, number of implemented words; must be 1..2**ADDR_W.
WAIT, 1, wait states inserted per access; legal range 0..255.
INIT_ZERO, 1, when 1, reset clears every memory word; when 0, reset leaves contents unchanged.

Ports:
iRAM_CLK  input  1  clock; all state changes on the rising edge.
iRAM_RST  input  1  reset, synchronous, active-high.
iRAM_REQ  input  1  access request; sampled only when oRAM_BUSY=0.
iRAM_WE  input  1  1 = write, 0 = read.
iRAM_BE  input  DATA_W/8  byte-lane write enables; bit n selects bits [8n+7:8n].
iRAM_ADDR  input  ADDR_W  word address.
iRAM_DATA  input  DATA_W  write data.
oRAM_DATA  output  DATA_W  read data, registered.
oRAM_ACK  output  1  one-cycle completion pulse.
oRAM_ERR  output  1  error flag; valid only while oRAM_ACK=1.
oRAM_BUSY  output  1  transaction in wait phase; new requests are ignored.

Behaviour:
- Reset: synchronous, active-high, dominates every other input.
  - At a reset edge: state=IDLE, wait counter=0, oRAM_DATA=0, oRAM_ACK=0, oRAM_ERR=0, oRAM_BUSY=0.
  - If INIT_ZERO=1, all DEPTH words are cleared.
- FSM states: IDLE, WAIT, DONE.
- Acceptance:
  - A request is accepted at a rising edge where state is IDLE or DONE and iRAM_REQ=1.
  - At acceptance, ADDR, WE, BE and write data are latched. Later input changes have no effect on the transaction.
- Timing (accept edge = edge 0, W = WAIT):
  - W=0: the access occurs at edge 0; next state is DONE.
  - W>0: next state is WAIT with counter=W-1. WAIT decrements each edge. When counter=0, the access occurs at that edge and the next state is DONE.
  - The access always happens at edge W.
  - oRAM_ACK is 1 for exactly the one cycle after edge W, i.e. latency W+1 cycles.
  - oRAM_BUSY=1 exactly while state=WAIT, i.e. W cycles per transaction.
- DONE:
  - Without a new request at the next edge, the state returns to IDLE.
  - A request present at the next edge is accepted there (back-to-back).
  - Maximum throughput is one transaction per W+1 cycles. With W=0, a request held high gives one access and one ACK every cycle.
- REQ while BUSY: ignored entirely, with no queuing. A pulse ending before BUSY falls is lost.
- Write:
  - At the access edge, only lanes with BE=1 are updated.
  - BE=0 on all lanes still completes with ACK and changes nothing.
  - oRAM_DATA is unchanged by writes.
- Read:
  - BE is ignored; the full word is loaded into oRAM_DATA at the access edge.
  - oRAM_DATA holds its value until the next read completes or reset.
- Ordering: a read accepted after a write's access edge returns the written data. Transactions complete strictly in acceptance order.
- Out of range (latched address >= DEPTH):
  - ACK occurs with the normal latency, and oRAM_ERR=1 during that ACK cycle.
  - A write is suppressed; a read loads 0 into oRAM_DATA.
  - oRAM_ERR=0 in all other cycles.
- Reset mid-transaction:
  - A transaction whose access edge has not yet occurred is aborted: no write, no ACK.
  - If reset coincides with the access edge, reset wins and the write is not committed.
- Widths: the counter is 8 bits. ADDR is compared against DEPTH at ADDR_W+1 bits, so DEPTH=2**ADDR_W never flags an error.

Test Plan:
1. WAIT=2, after reset: write 0xDEADBEEF to 0x10 with BE=4'b1111, accepted at edge 0 -> BUSY=1 for 2 cycles; ACK=1 only in the cycle after edge 2, with ERR=0. Then read 0x10 -> ACK 3 cycles after acceptance and oRAM_DATA=0xDEADBEEF.
2. Byte lanes: write 0x11223344 to 0x10 with BE=4'b0101 over 0xDEADBEEF -> reading 0x10 returns 0xDE22BE44. A later write with BE=0 -> ACK is given and the read still returns 0xDE22BE44.
3. Busy drop: WAIT=3, write to 0x20 accepted; pulse a second write (0x21, 0xCAFEF00D) during a BUSY cycle -> exactly one ACK. Reading 0x21 returns 0 after reset with INIT_ZERO=1.
4. WAIT=0 streaming: preload 0x0..0x3 with 0xA0..0xA3, then hold REQ high for 4 cycles reading addresses 0,1,2,3 -> ACK high for 4 consecutive cycles; oRAM_DATA=0xA0,0xA1,0xA2,0xA3 in successive cycles; BUSY stays 0.
5. DEPTH=200: write 0x55 to 0xF0 -> ACK=1 with ERR=1. Reading 0xF0 -> ERR=1 and oRAM_DATA=0. Reading 0xC7 -> ERR=0.
6. WAIT=3: write 0x12345678 to 0x30 accepted at edge 0; assert reset at edge 2 -> no ACK, all outputs 0 from the next cycle. Reading 0x30 after reset returns 0.

Source files
------------

// File: rtl/memory_ram_ws.sv
`default_nettype none
// ============================================================================
// Module   : memory_ram_ws
// Purpose  : Parametrised single-port synchronous RAM with per-byte write
//            enables, programmable wait states, a REQ/ACK handshake with a
//            busy indication, and an out-of-range error response.
// Ports    : iRAM_CLK   - clock, rising edge active
//            iRAM_RST   - synchronous active-high reset
//            iRAM_REQ   - access request (ignored while oRAM_BUSY=1)
//            iRAM_WE    - 1 = write, 0 = read
//            iRAM_BE    - byte-lane write enables
//            iRAM_ADDR  - word address
//            iRAM_DATA  - write data
//            oRAM_DATA  - registered read data
//            oRAM_ACK   - one-cycle completion pulse
//            oRAM_ERR   - out-of-range flag, valid with oRAM_ACK
//            oRAM_BUSY  - transaction in its wait phase
// Revision : 1.0 - initial release
// ============================================================================
module memory_ram_ws #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int WAIT      = 1,
    parameter int INIT_ZERO = 1
) (
    input  logic                iRAM_CLK,
    input  logic                iRAM_RST,
    input  logic                iRAM_REQ,
    input  logic                iRAM_WE,
    input  logic [DATA_W/8-1:0] iRAM_BE,
    input  logic [ADDR_W-1:0]   iRAM_ADDR,
    input  logic [DATA_W-1:0]   iRAM_DATA,
    output logic [DATA_W-1:0]   oRAM_DATA,
    output logic                oRAM_ACK,
    output logic                oRAM_ERR,
    output logic                oRAM_BUSY
);

    localparam int c_BE_W = DATA_W / 8;

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    // One extra bit so that DEPTH = 2**ADDR_W is representable and every
    // address compares as in range.
    localparam logic [ADDR_W:0] c_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [7:0]      c_WAIT_LOAD = (WAIT > 0) ? 8'(WAIT - 1) : 8'd0;

    logic [1:0]          r_state;
    logic [7:0]          r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_we;
    logic [c_BE_W-1:0]   r_be;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack;
    logic                r_err;
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    logic                w_accept;
    logic                w_access;
    logic [ADDR_W-1:0]   w_acc_addr;
    logic                w_acc_we;
    logic [c_BE_W-1:0]   w_acc_be;
    logic [DATA_W-1:0]   w_acc_data;
    logic                w_in_range;

    assign w_accept = ((r_state == c_IDLE) || (r_state == c_DONE)) && iRAM_REQ;

    // With no wait states the access happens on the accept edge itself, so
    // the live inputs are used; otherwise the latched copies are used.
    always_comb begin
        w_access   = 1'b0;
        w_acc_addr = r_addr;
        w_acc_we   = r_we;
        w_acc_be   = r_be;
        w_acc_data = r_wdata;
        if (WAIT == 0) begin
            w_access   = w_accept;
            w_acc_addr = iRAM_ADDR;
            w_acc_we   = iRAM_WE;
            w_acc_be   = iRAM_BE;
            w_acc_data = iRAM_DATA;
        end else begin
            w_access   = (r_state == c_WAIT) && (r_cnt == 8'd0);
        end
    end

    assign w_in_range = ({1'b0, w_acc_addr} < c_DEPTH);

    // Control path: FSM, latches, handshake outputs and read data.
    always_ff @(posedge iRAM_CLK) begin
        if (iRAM_RST) begin
            r_state <= c_IDLE;
            r_cnt   <= 8'd0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ack <= w_access;
            r_err <= w_access && !w_in_range;

            if (w_access && !w_acc_we) begin
                r_rdata <= w_in_range ? r_mem[w_acc_addr] : '0;
            end

            case (r_state)
                c_IDLE, c_DONE: begin
                    if (iRAM_REQ) begin
                        r_addr  <= iRAM_ADDR;
                        r_we    <= iRAM_WE;
                        r_be    <= iRAM_BE;
                        r_wdata <= iRAM_DATA;
                        r_cnt   <= c_WAIT_LOAD;
                        r_state <= (WAIT == 0) ? c_DONE : c_WAIT;
                    end else begin
                        r_state <= c_IDLE;
                    end
                end
                c_WAIT: begin
                    if (r_cnt == 8'd0) begin
                        r_state <= c_DONE;
                    end else begin
                        r_cnt <= r_cnt - 8'd1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Storage. Reset always blocks the write, so a reset landing on the
    // access edge leaves memory untouched (apart from the optional clear).
    always_ff @(posedge iRAM_CLK) begin
        if (iRAM_RST) begin
            if (INIT_ZERO != 0) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end
        end else if (w_access && w_acc_we && w_in_range) begin
            for (int b = 0; b < c_BE_W; b++) begin
                if (w_acc_be[b]) begin
                    r_mem[w_acc_addr][8*b +: 8] <= w_acc_data[8*b +: 8];
                end
            end
        end
    end

    assign oRAM_DATA = r_rdata;
    assign oRAM_ACK  = r_ack;
    assign oRAM_ERR  = r_err;
    assign oRAM_BUSY = (r_state == c_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_memory_ram_ws.sv
`default_nettype none
// ============================================================================
// Module   : tb_memory_ram_ws
// Purpose  : Self-checking bench for memory_ram_ws. Four instances with
//            different WAIT/DEPTH settings; expected completions are queued
//            at issue time and matched against every ACK.
// Revision : 1.0 - initial release
// ============================================================================
module tb_memory_ram_ws;

    localparam int c_WAIT [4] = '{2, 3, 0, 1};
    localparam int c_DEP  [4] = '{256, 256, 256, 200};

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst   [4];
    logic        req   [4];
    logic        we    [4];
    logic [3:0]  be    [4];
    logic [7:0]  addr  [4];
    logic [31:0] wdata [4];
    logic [31:0] rdata [4];
    logic        ack   [4];
    logic        err   [4];
    logic        busy  [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            memory_ram_ws #(
                .DATA_W    (32),
                .ADDR_W    (8),
                .DEPTH     (c_DEP[g]),
                .WAIT      (c_WAIT[g]),
                .INIT_ZERO (1)
            ) u_dut (
                .iRAM_CLK  (clk),
                .iRAM_RST  (rst[g]),
                .iRAM_REQ  (req[g]),
                .iRAM_WE   (we[g]),
                .iRAM_BE   (be[g]),
                .iRAM_ADDR (addr[g]),
                .iRAM_DATA (wdata[g]),
                .oRAM_DATA (rdata[g]),
                .oRAM_ACK  (ack[g]),
                .oRAM_ERR  (err[g]),
                .oRAM_BUSY (busy[g])
            );
        end
    endgenerate

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    typedef struct {
        int          cyc;
        int          k;
        bit          rd;
        bit          err;
        logic [31:0] data;
    } exp_t;

    exp_t q[$];

    // Drive a request just after a rising edge; the following edge accepts it
    // and ACK must be seen in the cycle after edge W of that transaction.
    task automatic issue(input int k, input bit we_i, input logic [3:0] be_i,
                         input logic [7:0] a, input logic [31:0] d,
                         input bit track, input bit e_err, input logic [31:0] e_data);
        exp_t e;
        @(posedge clk); #1;
        we[k] = we_i; be[k] = be_i; addr[k] = a; wdata[k] = d; req[k] = 1'b1;
        if (track) begin
            e.cyc = cyc + 1 + c_WAIT[k]; e.k = k; e.rd = !we_i;
            e.err = e_err; e.data = e_data;
            q.push_back(e);
        end
    endtask

    task automatic finish_xfer(input int k);
        @(posedge clk); #1;
        req[k] = 1'b0;
        for (int i = 0; i < c_WAIT[k]; i++) begin
            @(negedge clk);
            chk("busy_wait", 32'(busy[k]), 32'd1);
        end
        @(negedge clk);
        chk("busy_ack", 32'(busy[k]), 32'd0);
    endtask

    task automatic xfer(input int k, input bit we_i, input logic [3:0] be_i,
                        input logic [7:0] a, input logic [31:0] d,
                        input bit e_err, input logic [31:0] e_data);
        issue(k, we_i, be_i, a, d, 1'b1, e_err, e_data);
        finish_xfer(k);
    endtask

    task automatic check_zero_outputs(input int k);
        chk("rst_ack",  32'(ack[k]),  32'd0);
        chk("rst_err",  32'(err[k]),  32'd0);
        chk("rst_busy", 32'(busy[k]), 32'd0);
        chk("rst_data", rdata[k],     32'd0);
    endtask

    // Completion monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                if (ack[k]) begin
                    if (q.size() == 0) begin
                        chk("spurious_ack", 32'(ack[k]), 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("ack_inst",  32'(k),      32'(e.k));
                        chk("ack_cycle", 32'(cyc),    32'(e.cyc));
                        chk("ack_err",   32'(err[k]), 32'(e.err));
                        if (e.rd) chk("rdata", rdata[k], e.data);
                    end
                end else begin
                    chk("err_idle", 32'(err[k]), 32'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1; req[k] = 1'b0; we[k] = 1'b0;
            be[k] = '0; addr[k] = '0; wdata[k] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) check_zero_outputs(k);

        // Basic write/read with two wait states.
        xfer(0, 1'b1, 4'hF, 8'h10, 32'hDEADBEEF, 1'b0, 32'h0);
        xfer(0, 1'b0, 4'h0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF);

        // Byte lanes, then an all-lanes-off write.
        xfer(0, 1'b1, 4'b0101, 8'h10, 32'h11223344, 1'b0, 32'h0);
        xfer(0, 1'b0, 4'hF,    8'h10, 32'h0,        1'b0, 32'hDE22BE44);
        xfer(0, 1'b1, 4'b0000, 8'h10, 32'hFFFFFFFF, 1'b0, 32'h0);
        xfer(0, 1'b0, 4'h0,    8'h10, 32'h0,        1'b0, 32'hDE22BE44);

        // Request pulsed during BUSY is dropped (WAIT=3).
        issue(1, 1'b1, 4'hF, 8'h20, 32'h0BADF00D, 1'b1, 1'b0, 32'h0);
        @(posedge clk); #1; req[1] = 1'b0;
        @(posedge clk); #1;
        we[1] = 1'b1; be[1] = 4'hF; addr[1] = 8'h21; wdata[1] = 32'hCAFEF00D; req[1] = 1'b1;
        @(posedge clk); #1; req[1] = 1'b0;
        repeat (4) @(negedge clk);
        xfer(1, 1'b0, 4'hF, 8'h21, 32'h0, 1'b0, 32'h0);
        xfer(1, 1'b0, 4'hF, 8'h20, 32'h0, 1'b0, 32'h0BADF00D);

        // Reset before the access edge aborts the write.
        issue(1, 1'b1, 4'hF, 8'h30, 32'h12345678, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1; req[1] = 1'b0;
        @(posedge clk); #1; rst[1] = 1'b1;
        @(posedge clk); #1; rst[1] = 1'b0;
        @(negedge clk);
        check_zero_outputs(1);
        repeat (4) @(negedge clk);
        xfer(1, 1'b0, 4'hF, 8'h30, 32'h0, 1'b0, 32'h0);

        // Reset landing exactly on the access edge wins.
        xfer(1, 1'b1, 4'hF, 8'h32, 32'h00000077, 1'b0, 32'h0);
        xfer(1, 1'b0, 4'hF, 8'h32, 32'h0,        1'b0, 32'h00000077);
        issue(1, 1'b1, 4'hF, 8'h31, 32'h00000077, 1'b0, 1'b0, 32'h0);
        @(posedge clk); #1; req[1] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1; rst[1] = 1'b1;
        @(posedge clk); #1; rst[1] = 1'b0;
        @(negedge clk);
        check_zero_outputs(1);
        xfer(1, 1'b0, 4'hF, 8'h31, 32'h0, 1'b0, 32'h0);

        // Zero wait states: preload then stream four reads back to back.
        for (int a = 0; a < 4; a++) begin
            xfer(2, 1'b1, 4'hF, 8'(a), 32'hA0 + 32'(a), 1'b0, 32'h0);
        end
        for (int a = 0; a < 4; a++) begin
            issue(2, 1'b0, 4'h0, 8'(a), 32'h0, 1'b1, 1'b0, 32'hA0 + 32'(a));
            chk("busy_stream", 32'(busy[2]), 32'd0);
        end
        @(posedge clk); #1; req[2] = 1'b0;
        repeat (3) @(negedge clk);

        // DEPTH=200: out-of-range accesses.
        xfer(3, 1'b1, 4'hF, 8'hF0, 32'h00000055, 1'b1, 32'h0);
        xfer(3, 1'b1, 4'hF, 8'hC7, 32'h00000055, 1'b0, 32'h0);
        xfer(3, 1'b0, 4'hF, 8'hC7, 32'h0,        1'b0, 32'h00000055);
        xfer(3, 1'b0, 4'hF, 8'hF0, 32'h0,        1'b1, 32'h0);
        xfer(3, 1'b0, 4'hF, 8'hC7, 32'h0,        1'b0, 32'h00000055);

        repeat (4) @(negedge clk);
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
